// File: rtl/zero_compare_pipe.sv
// zero_compare_pipe: pipelined A-vs-zero / A-vs-B (signed or unsigned) comparator producing
// six relation flags plus a TAKEN bit for the selected branch/set condition.
// Latency LATENCY (1 or 2) cycles from input transfer to out_valid_o; one result per cycle unstalled.
// Backpressure: in_ready_o follows the stage advance chain; a stalled result holds every output stable.
// Build macro ZC_TAKEN_COUNT_EN adds the saturating taken-result counter on taken_count_o.
module zero_compare_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [1:0]         mode_i,
  input  logic [2:0]         cond_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               lt_o,
  output logic               le_o,
  output logic               gt_o,
  output logic               ge_o,
  output logic               eq_o,
  output logic               ne_o,
  output logic               taken_o,
  input  logic               clr_count_i,
  output logic [COUNT_W-1:0] taken_count_o
);

  localparam logic [1:0] MODE_SIGNED   = 2'd1;
  localparam logic [1:0] MODE_UNSIGNED = 2'd2;

  localparam logic [2:0] COND_LT     = 3'd0;
  localparam logic [2:0] COND_LE     = 3'd1;
  localparam logic [2:0] COND_GT     = 3'd2;
  localparam logic [2:0] COND_GE     = 3'd3;
  localparam logic [2:0] COND_EQ     = 3'd4;
  localparam logic [2:0] COND_NE     = 3'd5;
  localparam logic [2:0] COND_ALWAYS = 3'd6;

  typedef struct packed {
    logic taken;
    logic ne;
    logic eq;
    logic ge;
    logic gt;
    logic le;
    logic lt;
  } flags_t;

  // A is sign-extended except in unsigned mode; mode 0 (and 3) is a signed compare against zero.
  function automatic logic [WIDTH:0] ext_a(input logic [WIDTH-1:0] a, input logic [1:0] mode);
    ext_a = (mode == MODE_UNSIGNED) ? {1'b0, a} : {a[WIDTH-1], a};
  endfunction

  // X is B extended to match A's interpretation, or zero for the compare-against-zero modes.
  function automatic logic [WIDTH:0] ext_x(input logic [WIDTH-1:0] b, input logic [1:0] mode);
    case (mode)
      MODE_SIGNED:   ext_x = {b[WIDTH-1], b};
      MODE_UNSIGNED: ext_x = {1'b0, b};
      default:       ext_x = '0;
    endcase
  endfunction

  // One extra bit of headroom means the difference never overflows, so its top bit is the
  // true "A below X" indication in both the signed and the unsigned (borrow) interpretation.
  function automatic flags_t eval_flags(input logic [WIDTH:0] a_ext,
                                        input logic [WIDTH:0] x_ext,
                                        input logic [2:0]     cond);
    logic [WIDTH:0] diff;
    flags_t         f;
    f      = '0;
    diff   = a_ext - x_ext;
    f.lt   = diff[WIDTH];
    f.eq   = (a_ext == x_ext);
    f.le   = f.lt | f.eq;
    f.gt   = ~f.le;
    f.ge   = ~f.lt;
    f.ne   = ~f.eq;
    case (cond)
      COND_LT:     f.taken = f.lt;
      COND_LE:     f.taken = f.le;
      COND_GT:     f.taken = f.gt;
      COND_GE:     f.taken = f.ge;
      COND_EQ:     f.taken = f.eq;
      COND_NE:     f.taken = f.ne;
      COND_ALWAYS: f.taken = 1'b1;
      default:     f.taken = 1'b0;
    endcase
    return f;
  endfunction

  // Final (result) stage, shared by both latency configurations.
  flags_t res_q;
  flags_t res_d;
  logic   res_vld_q;
  logic   res_adv;       // result stage can take a new entry this cycle
  logic   res_feed_vld;  // upstream offers a valid entry to the result stage

  assign res_adv = ~res_vld_q | out_ready_i;

  generate
    if (LATENCY == 2) begin : g_lat2
      logic             s1_vld_q;
      logic [WIDTH:0]   s1_a_q;
      logic [WIDTH:0]   s1_x_q;
      logic [2:0]       s1_cond_q;
      logic [WIDTH:0]   s1_a_d;
      logic [WIDTH:0]   s1_x_d;

      assign in_ready_o   = ~s1_vld_q | res_adv;
      assign res_feed_vld = s1_vld_q;

      // Operand extension happens ahead of the stage-1 register so stage 2 only subtracts.
      always_comb begin
        s1_a_d = ext_a(a_i, mode_i);
        s1_x_d = ext_x(b_i, mode_i);
      end

      // Stage-1 valid bit: refills (or empties) whenever the stage advances.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          s1_vld_q <= 1'b0;
        end else if (in_ready_o) begin
          s1_vld_q <= in_valid_i;
        end
      end

      // Stage-1 operand capture, only on a real input transfer.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          s1_a_q    <= '0;
          s1_x_q    <= '0;
          s1_cond_q <= '0;
        end else if (in_valid_i && in_ready_o) begin
          s1_a_q    <= s1_a_d;
          s1_x_q    <= s1_x_d;
          s1_cond_q <= cond_i;
        end
      end

      // Flags for stage 2 come from the registered, already-extended operands.
      always_comb begin
        res_d = eval_flags(s1_a_q, s1_x_q, s1_cond_q);
      end
    end else if (LATENCY == 1) begin : g_lat1
      assign in_ready_o   = res_adv;
      assign res_feed_vld = in_valid_i;

      // Flags are computed straight from the input operands.
      always_comb begin
        res_d = eval_flags(ext_a(a_i, mode_i), ext_x(b_i, mode_i), cond_i);
      end
    end else begin : g_lat_bad
      $error("zero_compare_pipe: LATENCY must be 1 or 2");
    end
  endgenerate

  // Result valid bit: cleared on reset so in-flight work never surfaces after a reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_vld_q <= 1'b0;
    end else if (res_adv) begin
      res_vld_q <= res_feed_vld;
    end
  end

  // Result flags load only on a transfer into the stage, so they hold through stalls and idles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q <= '0;
    end else if (res_adv && res_feed_vld) begin
      res_q <= res_d;
    end
  end

  assign out_valid_o = res_vld_q;
  assign lt_o        = res_q.lt;
  assign le_o        = res_q.le;
  assign gt_o        = res_q.gt;
  assign ge_o        = res_q.ge;
  assign eq_o        = res_q.eq;
  assign ne_o        = res_q.ne;
  assign taken_o     = res_q.taken;

`ifdef ZC_TAKEN_COUNT_EN
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;

  // Clear wins over a same-cycle increment; increments stop at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_count_i) begin
      cnt_d = '0;
    end else if (res_vld_q && out_ready_i && res_q.taken && (cnt_q != {COUNT_W{1'b1}})) begin
      cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  // Taken-result counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign taken_count_o = cnt_q;
`else
  logic unused_clr_count;

  assign unused_clr_count = clr_count_i;
  assign taken_count_o    = '0;
`endif

endmodule

// File: tb/tb_zero_compare_pipe.sv
// Testbench for zero_compare_pipe: directed boundary cases, backpressure, reset, counter,
// then a randomized stream checked against a queue-based reference model.
module tb_zero_compare_pipe;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 2;
  localparam int COUNT_W = 4;
`ifdef ZC_TAKEN_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int CNT_MAX = (1 << COUNT_W) - 1;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic [1:0]         mode_i;
  logic [2:0]         cond_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic               lt_o, le_o, gt_o, ge_o, eq_o, ne_o, taken_o;
  logic               clr_count_i;
  logic [COUNT_W-1:0] taken_count_o;

  zero_compare_pipe #(.WIDTH(WIDTH), .LATENCY(LATENCY), .COUNT_W(COUNT_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .mode_i       (mode_i),
    .cond_i       (cond_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .lt_o         (lt_o),
    .le_o         (le_o),
    .gt_o         (gt_o),
    .ge_o         (ge_o),
    .eq_o         (eq_o),
    .ne_o         (ne_o),
    .taken_o      (taken_o),
    .clr_count_i  (clr_count_i),
    .taken_count_o(taken_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Output vector order: {taken, ne, eq, ge, gt, le, lt}
  logic [6:0] outvec;
  assign outvec = {taken_o, ne_o, eq_o, ge_o, gt_o, le_o, lt_o};

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_out    = 0;
  logic [6:0] exp_q[$];
  int         model_cnt = 0;
  bit         hold_pending = 1'b0;
  logic [6:0] hold_vec;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned relational operators on the operands.
  function automatic logic [6:0] ref_flags(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] mode, input logic [2:0] cond);
    bit lt, eq, tk;
    case (mode)
      2'd1:    begin lt = ($signed(a) < $signed(b)); eq = (a == b); end
      2'd2:    begin lt = (a < b);                   eq = (a == b); end
      default: begin lt = ($signed(a) < 32'sd0);     eq = (a == 32'd0); end
    endcase
    case (cond)
      3'd0: tk = lt;
      3'd1: tk = lt || eq;
      3'd2: tk = !(lt || eq);
      3'd3: tk = !lt;
      3'd4: tk = eq;
      3'd5: tk = !eq;
      3'd6: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    return {tk, !eq, eq, !lt, !(lt || eq), lt || eq, lt};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic sample_point();
    @(negedge clk_i);
    #1;
  endtask

  // Scoreboard and protocol checks for the transfers that happen on the coming edge.
  task automatic monitor();
    logic [6:0] e;
    bit         out_x;
    if (hold_pending) begin
      check("hold_vld", out_valid_o, 1'b1);
      check("hold_dat", outvec, hold_vec);
    end
    check("count", taken_count_o, model_cnt);
    out_x = out_valid_o && out_ready_i;
    e = '0;
    if (out_x) begin
      check("q_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", outvec, e);
      end
      n_out++;
    end
    hold_pending = out_valid_o && !out_ready_i;
    hold_vec     = outvec;
    if (in_valid_i && in_ready_o) exp_q.push_back(ref_flags(a_i, b_i, mode_i, cond_i));
    if (CNT_EN) begin
      if (clr_count_i) model_cnt = 0;
      else if (out_x && e[6] && model_cnt != CNT_MAX) model_cnt++;
    end
  endtask

  task automatic finish_cycle();
    monitor();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step();
    sample_point();
    finish_cycle();
  endtask

  task automatic drain();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    clr_count_i = 1'b0;
    repeat (4) step();
    check("drain", exp_q.size(), 0);
  endtask

  // Single operation into an empty pipe: exact latency and exact flag pattern.
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] mode, input logic [2:0] cond, input logic [6:0] exp);
    drain();
    in_valid_i = 1'b1; a_i = a; b_i = b; mode_i = mode; cond_i = cond;
    step();
    in_valid_i = 1'b0;
    sample_point();
    check({tag, "_early"}, out_valid_o, 1'b0);
    finish_cycle();
    sample_point();
    check({tag, "_vld"}, out_valid_o, 1'b1);
    check({tag, "_flags"}, outvec, exp);
    finish_cycle();
  endtask

  logic [31:0] bp_a[8];
  logic [31:0] bp_b[8];
  logic [1:0]  bp_m[8];
  logic [2:0]  bp_c[8];

  initial begin
    int  sent, base;
    bit  acc;
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0; clr_count_i = 1'b0;
    a_i = '0; b_i = '0; mode_i = '0; cond_i = '0;

    // Reset state
    sample_point();
    check("rst_vld", out_valid_o, 1'b0);
    check("rst_flags", outvec, 7'b0);
    check("rst_cnt", taken_count_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    sample_point();
    check("rst_rdy", in_ready_o, 1'b1);
    finish_cycle();

    // Directed relations and boundaries
    directed("zero_eq",   32'h0000_0000, 32'h1234_5678, 2'd0, 3'd4, 7'b1011010);
    directed("min_s_lt",  32'h8000_0000, 32'h0000_0001, 2'd1, 3'd0, 7'b1100011);
    directed("min_u_gt",  32'h8000_0000, 32'h0000_0001, 2'd2, 3'd0, 7'b0101100);
    directed("max_alw",   32'h7FFF_FFFF, 32'h0000_0000, 2'd0, 3'd6, 7'b1101100);
    directed("max_nev",   32'h7FFF_FFFF, 32'h0000_0000, 2'd0, 3'd7, 7'b0101100);
    directed("ones_u_gt", 32'hFFFF_FFFF, 32'h0000_0000, 2'd2, 3'd2, 7'b1101100);
    directed("m3_neg",    32'hFFFF_FFFF, 32'h0000_0005, 2'd3, 3'd0, 7'b1100011);

    // Backpressure: 8 back-to-back inputs, consumer stalls for cycles 3-6
    drain();
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = pick(); bp_b[i] = pick();
      bp_m[i] = 2'($urandom_range(0, 3)); bp_c[i] = 3'($urandom_range(0, 7));
    end
    sent = 0;
    base = n_out;
    for (int c = 0; c < 20; c++) begin
      out_ready_i = !(c >= 3 && c <= 6);
      in_valid_i  = (sent < 8);
      if (sent < 8) begin
        a_i = bp_a[sent]; b_i = bp_b[sent]; mode_i = bp_m[sent]; cond_i = bp_c[sent];
      end
      sample_point();
      if (c < 10) check("bp_rdy", in_ready_o, !(c >= 3 && c <= 6));
      acc = in_valid_i && in_ready_o;
      finish_cycle();
      if (acc) sent++;
    end
    drain();
    check("bp_count", n_out - base, 8);

    // Reset with two results in flight
    out_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1'b1; a_i = pick(); b_i = pick(); mode_i = 2'd1; cond_i = 3'd6;
      step();
    end
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    exp_q.delete();
    hold_pending = 1'b0;
    model_cnt = 0;
    sample_point();
    check("mid_rst_vld", out_valid_o, 1'b0);
    check("mid_rst_flags", outvec, 7'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    sample_point();
    check("mid_rel_rdy", in_ready_o, 1'b1);
    check("mid_rel_vld", out_valid_o, 1'b0);
    finish_cycle();
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_point();
      check("no_stale", out_valid_o, 1'b0);
      finish_cycle();
    end

    // Counter saturation, then clear coinciding with a taken transfer
    for (int i = 0; i < 20; i++) begin
      in_valid_i = 1'b1; a_i = $urandom(); b_i = $urandom(); mode_i = 2'd0; cond_i = 3'd6;
      step();
    end
    drain();
    check("cnt_sat", taken_count_o, CNT_EN ? CNT_MAX : 0);
    in_valid_i = 1'b1; a_i = 32'h5; mode_i = 2'd0; cond_i = 3'd6;
    step();
    in_valid_i = 1'b0;
    step();
    clr_count_i = 1'b1;
    sample_point();
    check("clr_vld", out_valid_o & taken_o, 1'b1);
    finish_cycle();
    clr_count_i = 1'b0;
    sample_point();
    check("cnt_clr", taken_count_o, 0);
    finish_cycle();

    // Randomized stream
    for (int i = 0; i < 1500; i++) begin
      in_valid_i  = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      clr_count_i = ($urandom_range(0, 49) == 0);
      mode_i = 2'($urandom_range(0, 3));
      cond_i = 3'($urandom_range(0, 7));
      a_i = pick();
      b_i = ($urandom_range(0, 4) == 0) ? a_i : pick();
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
